// File: rtl/id_ex_register_if.sv
// Decode/execute boundary bundle for the ID/EX pipeline register.
// The decode side (master) drives the *_i fields and the stall/flush/valid
// controls. The register (slave) drives the registered *_o fields, the
// load-use hazard flag and the bubble counter.
interface id_ex_register_if #(
    parameter int CNT_W = 16
);
    // Pipeline control from upstream / back end
    logic             stall_i;
    logic             flush_i;
    logic             valid_i;

    // Decode-stage instruction
    logic [2:0]       ALUOp_i;
    logic             ALUSrc_i;
    logic             RegWrite_i;
    logic             MemtoReg_i;
    logic             MemRead_i;
    logic             MemWrite_i;
    logic [31:0]      RS1data_i;
    logic [31:0]      RS2data_i;
    logic [31:0]      Imm_i;
    logic [4:0]       RS1addr_i;
    logic [4:0]       RS2addr_i;
    logic [4:0]       RDaddr_i;

    // Execute-stage instruction
    logic [2:0]       ALUOp_o;
    logic             ALUSrc_o;
    logic             RegWrite_o;
    logic             MemtoReg_o;
    logic             MemRead_o;
    logic             MemWrite_o;
    logic [31:0]      RS1data_o;
    logic [31:0]      RS2data_o;
    logic [31:0]      Imm_o;
    logic [4:0]       RS1addr_o;
    logic [4:0]       RS2addr_o;
    logic [4:0]       RDaddr_o;
    logic             valid_o;

    // Status
    logic             hazard_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    modport master (
        output stall_i, flush_i, valid_i,
        output ALUOp_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
        output RS1data_i, RS2data_i, Imm_i, RS1addr_i, RS2addr_i, RDaddr_i,
        input  ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
        input  RS1data_o, RS2data_o, Imm_o, RS1addr_o, RS2addr_o, RDaddr_o,
        input  valid_o, hazard_o, bubble_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i,
        input  ALUOp_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
        input  RS1data_i, RS2data_i, Imm_i, RS1addr_i, RS2addr_i, RDaddr_i,
        output ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
        output RS1data_o, RS2data_o, Imm_o, RS1addr_o, RS2addr_o, RDaddr_o,
        output valid_o, hazard_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection.
// Edge priority: reset, stall (hold everything), flush or hazard (counted
// bubble), no valid instruction (uncounted bubble), otherwise load.
// A bubble is the all-zero payload, so valid, controls and RDaddr are all 0.
module id_ex_register #(
    parameter int CNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    id_ex_register_if.slave    bus
);

    typedef struct packed {
        logic        valid;
        logic [2:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
    } stage_t;

    stage_t           stage_d, stage_q, stage_in;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             hazard;

    // Load in EX whose destination is a source of the decode instruction.
    // RS2 is always compared, even for I-type; an occasional false stall is fine.
    always_comb begin
        hazard = stage_q.mem_read & stage_q.valid & (stage_q.rd_addr != 5'd0) &
                 bus.valid_i &
                 ((stage_q.rd_addr == bus.RS1addr_i) | (stage_q.rd_addr == bus.RS2addr_i));
    end

    // Pack the decode-side fields into one payload.
    always_comb begin
        stage_in            = '0;
        stage_in.valid      = 1'b1;
        stage_in.alu_op     = bus.ALUOp_i;
        stage_in.alu_src    = bus.ALUSrc_i;
        stage_in.reg_write  = bus.RegWrite_i;
        stage_in.mem_to_reg = bus.MemtoReg_i;
        stage_in.mem_read   = bus.MemRead_i;
        stage_in.mem_write  = bus.MemWrite_i;
        stage_in.rs1_data   = bus.RS1data_i;
        stage_in.rs2_data   = bus.RS2data_i;
        stage_in.imm        = bus.Imm_i;
        stage_in.rs1_addr   = bus.RS1addr_i;
        stage_in.rs2_addr   = bus.RS2addr_i;
        stage_in.rd_addr    = bus.RDaddr_i;
    end

    // Next payload and bubble count, by edge priority.
    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (bus.stall_i) begin
            stage_d = stage_q;
            cnt_d   = cnt_q;
        end else if (bus.flush_i || hazard) begin
            stage_d = '0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!bus.valid_i) begin
            stage_d = '0;
        end else begin
            stage_d = stage_in;
        end
    end

    // State registers; synchronous reset loads a bubble and clears the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    // Drive the execute-side view of the register.
    always_comb begin
        bus.valid_o      = stage_q.valid;
        bus.ALUOp_o      = stage_q.alu_op;
        bus.ALUSrc_o     = stage_q.alu_src;
        bus.RegWrite_o   = stage_q.reg_write;
        bus.MemtoReg_o   = stage_q.mem_to_reg;
        bus.MemRead_o    = stage_q.mem_read;
        bus.MemWrite_o   = stage_q.mem_write;
        bus.RS1data_o    = stage_q.rs1_data;
        bus.RS2data_o    = stage_q.rs2_data;
        bus.Imm_o        = stage_q.imm;
        bus.RS1addr_o    = stage_q.rs1_addr;
        bus.RS2addr_o    = stage_q.rs2_addr;
        bus.RDaddr_o     = stage_q.rd_addr;
        bus.hazard_o     = hazard;
        bus.bubble_cnt_o = cnt_q;
    end

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register: reset, pass-through, load-use,
// flush vs hazard, stall, reset during stall, and counter saturation.
module tb_id_ex_register;

    logic clk;
    logic rst;

    id_ex_register_if #(.CNT_W(16)) bus16 ();
    id_ex_register_if #(.CNT_W(2))  bus2 ();

    id_ex_register #(.CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus16)
    );

    id_ex_register #(.CNT_W(2)) dut_sat (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one edge; outputs settle 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus16.stall_i    = 1'b0;
        bus16.flush_i    = 1'b0;
        bus16.valid_i    = 1'b0;
        bus16.ALUOp_i    = 3'd0;
        bus16.ALUSrc_i   = 1'b0;
        bus16.RegWrite_i = 1'b0;
        bus16.MemtoReg_i = 1'b0;
        bus16.MemRead_i  = 1'b0;
        bus16.MemWrite_i = 1'b0;
        bus16.RS1data_i  = 32'd0;
        bus16.RS2data_i  = 32'd0;
        bus16.Imm_i      = 32'd0;
        bus16.RS1addr_i  = 5'd0;
        bus16.RS2addr_i  = 5'd0;
        bus16.RDaddr_i   = 5'd0;
    endtask

    task automatic drive_load(input logic [4:0] rd);
        clear_in();
        bus16.valid_i    = 1'b1;
        bus16.MemRead_i  = 1'b1;
        bus16.MemtoReg_i = 1'b1;
        bus16.RegWrite_i = 1'b1;
        bus16.ALUSrc_i   = 1'b1;
        bus16.RS1addr_i  = 5'd2;
        bus16.RDaddr_i   = rd;
    endtask

    task automatic drive_add(input logic [4:0] rs2);
        clear_in();
        bus16.valid_i    = 1'b1;
        bus16.ALUOp_i    = 3'b010;
        bus16.RegWrite_i = 1'b1;
        bus16.RS1addr_i  = 5'd3;
        bus16.RS2addr_i  = rs2;
        bus16.RDaddr_i   = 5'd9;
        bus16.RS1data_i  = 32'h0000_0011;
        bus16.RS2data_i  = 32'h0000_0022;
    endtask

    task automatic clear_sat();
        bus2.stall_i    = 1'b0;
        bus2.flush_i    = 1'b0;
        bus2.valid_i    = 1'b0;
        bus2.ALUOp_i    = 3'd0;
        bus2.ALUSrc_i   = 1'b0;
        bus2.RegWrite_i = 1'b0;
        bus2.MemtoReg_i = 1'b0;
        bus2.MemRead_i  = 1'b0;
        bus2.MemWrite_i = 1'b0;
        bus2.RS1data_i  = 32'd0;
        bus2.RS2data_i  = 32'd0;
        bus2.Imm_i      = 32'd0;
        bus2.RS1addr_i  = 5'd0;
        bus2.RS2addr_i  = 5'd0;
        bus2.RDaddr_i   = 5'd0;
    endtask

    // Driver and checks
    initial begin
        logic [2:0] sat_exp [5];
        sat_exp[0] = 3'd1; sat_exp[1] = 3'd2; sat_exp[2] = 3'd3;
        sat_exp[3] = 3'd3; sat_exp[4] = 3'd3;

        // Reset with arbitrary (hazard-like) inputs
        rst = 1'b1;
        clear_sat();
        drive_load(5'd7);
        bus16.RS2addr_i = 5'd7;
        bus16.RS1data_i = 32'hdead_beef;
        step();
        step();
        check("rst_valid",  {31'd0, bus16.valid_o},    32'd0);
        check("rst_aluop",  {29'd0, bus16.ALUOp_o},    32'd0);
        check("rst_ctrl",   {27'd0, bus16.ALUSrc_o, bus16.RegWrite_o, bus16.MemtoReg_o,
                                    bus16.MemRead_o, bus16.MemWrite_o}, 32'd0);
        check("rst_rd",     {27'd0, bus16.RDaddr_o},   32'd0);
        check("rst_rs1d",   bus16.RS1data_o,           32'd0);
        check("rst_cnt",    {16'd0, bus16.bubble_cnt_o}, 32'd0);
        check("rst_hazard", {31'd0, bus16.hazard_o},   32'd0);

        // Idle decode: uncounted bubble
        rst = 1'b0;
        clear_in();
        step();
        check("idle_valid", {31'd0, bus16.valid_o}, 32'd0);
        check("idle_cnt",   {16'd0, bus16.bubble_cnt_o}, 32'd0);

        // Pass-through
        clear_in();
        bus16.valid_i    = 1'b1;
        bus16.ALUOp_i    = 3'b011;
        bus16.RegWrite_i = 1'b1;
        bus16.ALUSrc_i   = 1'b1;
        bus16.RS1data_i  = 32'h1234_5678;
        bus16.RS2data_i  = 32'h0000_cafe;
        bus16.Imm_i      = 32'hffff_fffc;
        bus16.RS1addr_i  = 5'd1;
        bus16.RS2addr_i  = 5'd4;
        bus16.RDaddr_i   = 5'd5;
        step();
        check("pt_valid",  {31'd0, bus16.valid_o},    32'd1);
        check("pt_aluop",  {29'd0, bus16.ALUOp_o},    32'd3);
        check("pt_regwr",  {31'd0, bus16.RegWrite_o}, 32'd1);
        check("pt_alusrc", {31'd0, bus16.ALUSrc_o},   32'd1);
        check("pt_memrd",  {31'd0, bus16.MemRead_o},  32'd0);
        check("pt_rs1d",   bus16.RS1data_o,           32'h1234_5678);
        check("pt_rs2d",   bus16.RS2data_o,           32'h0000_cafe);
        check("pt_imm",    bus16.Imm_o,               32'hffff_fffc);
        check("pt_rs1a",   {27'd0, bus16.RS1addr_o},  32'd1);
        check("pt_rs2a",   {27'd0, bus16.RS2addr_o},  32'd4);
        check("pt_rd",     {27'd0, bus16.RDaddr_o},   32'd5);

        // Load-use: load x7 then add using x7 as RS2
        drive_load(5'd7);
        step();
        check("lu_load_memrd", {31'd0, bus16.MemRead_o}, 32'd1);
        check("lu_load_rd",    {27'd0, bus16.RDaddr_o},  32'd7);
        drive_add(5'd7);
        #1;
        check("lu_hazard_hi",  {31'd0, bus16.hazard_o},  32'd1);
        step();
        check("lu_bub_valid",  {31'd0, bus16.valid_o},   32'd0);
        check("lu_bub_memrd",  {31'd0, bus16.MemRead_o}, 32'd0);
        check("lu_bub_rd",     {27'd0, bus16.RDaddr_o},  32'd0);
        check("lu_bub_cnt",    {16'd0, bus16.bubble_cnt_o}, 32'd1);
        check("lu_hazard_lo",  {31'd0, bus16.hazard_o},  32'd0);
        step();
        check("lu_add_valid",  {31'd0, bus16.valid_o},   32'd1);
        check("lu_add_rd",     {27'd0, bus16.RDaddr_o},  32'd9);
        check("lu_add_aluop",  {29'd0, bus16.ALUOp_o},   32'd2);
        check("lu_add_rs2d",   bus16.RS2data_o,          32'h0000_0022);
        check("lu_add_cnt",    {16'd0, bus16.bubble_cnt_o}, 32'd1);

        // Load to x0: never a hazard; loaded as-is with RegWrite passed through
        drive_load(5'd0);
        step();
        check("x0_load_valid", {31'd0, bus16.valid_o},    32'd1);
        check("x0_load_memrd", {31'd0, bus16.MemRead_o},  32'd1);
        check("x0_load_regwr", {31'd0, bus16.RegWrite_o}, 32'd1);
        drive_add(5'd0);
        #1;
        check("x0_no_hazard",  {31'd0, bus16.hazard_o},  32'd0);
        step();
        check("x0_add_rd",     {27'd0, bus16.RDaddr_o},  32'd9);
        check("x0_add_cnt",    {16'd0, bus16.bubble_cnt_o}, 32'd1);

        // Flush together with hazard: one bubble, count +1
        drive_load(5'd7);
        step();
        drive_add(5'd7);
        bus16.flush_i = 1'b1;
        #1;
        check("fh_hazard",     {31'd0, bus16.hazard_o},  32'd1);
        step();
        check("fh_bub_valid",  {31'd0, bus16.valid_o},   32'd0);
        check("fh_cnt",        {16'd0, bus16.bubble_cnt_o}, 32'd2);
        bus16.flush_i = 1'b0;
        step();
        check("fh_add_rd",     {27'd0, bus16.RDaddr_o},  32'd9);
        check("fh_add_cnt",    {16'd0, bus16.bubble_cnt_o}, 32'd2);

        // Stall 3 cycles with changing inputs and flush held
        for (int i = 0; i < 3; i++) begin
            drive_load(5'(10 + i));
            bus16.RS1data_i = $urandom;
            bus16.stall_i   = 1'b1;
            bus16.flush_i   = 1'b1;
            step();
            check("st_valid", {31'd0, bus16.valid_o},  32'd1);
            check("st_rd",    {27'd0, bus16.RDaddr_o}, 32'd9);
            check("st_rs1d",  bus16.RS1data_o,         32'h0000_0011);
            check("st_cnt",   {16'd0, bus16.bubble_cnt_o}, 32'd2);
        end
        bus16.stall_i = 1'b0;
        step();
        check("st_rel_valid", {31'd0, bus16.valid_o},  32'd0);
        check("st_rel_rd",    {27'd0, bus16.RDaddr_o}, 32'd0);
        check("st_rel_cnt",   {16'd0, bus16.bubble_cnt_o}, 32'd3);

        // Hazard held through a stall, bubble after release
        drive_load(5'd7);
        step();
        drive_add(5'd7);
        bus16.RS1addr_i = 5'd7;
        bus16.RS2addr_i = 5'd8;
        bus16.stall_i   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("sh_hazard", {31'd0, bus16.hazard_o},  32'd1);
            step();
            check("sh_memrd",  {31'd0, bus16.MemRead_o}, 32'd1);
            check("sh_cnt",    {16'd0, bus16.bubble_cnt_o}, 32'd3);
        end
        bus16.stall_i = 1'b0;
        step();
        check("sh_bub_valid", {31'd0, bus16.valid_o}, 32'd0);
        check("sh_bub_cnt",   {16'd0, bus16.bubble_cnt_o}, 32'd4);

        // Reset during stall with a load in EX
        drive_load(5'd7);
        step();
        drive_add(5'd7);
        bus16.stall_i = 1'b1;
        rst = 1'b1;
        step();
        check("rs_valid", {31'd0, bus16.valid_o},   32'd0);
        check("rs_memrd", {31'd0, bus16.MemRead_o}, 32'd0);
        check("rs_cnt",   {16'd0, bus16.bubble_cnt_o}, 32'd0);
        check("rs_hazard",{31'd0, bus16.hazard_o},  32'd0);
        rst = 1'b0;
        clear_in();

        // Saturation on the 2-bit counter instance
        bus2.flush_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("sat_cnt", {30'd0, bus2.bubble_cnt_o}, {29'd0, sat_exp[i]});
        end
        bus2.flush_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
